// File: rtl/mc_rsp_model_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mc_rsp_model_if
//  Description : MC request/response bundle between a requester
//                (personality / phold) and the memory-controller responder.
//                master : requester side, drives mc_rq_* and mc_rs_stall
//                slave  : responder side, drives mc_rs_*, mc_rq_stall and
//                         mc_rs_flush_cmplt
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_rsp_model_if #(
    parameter int RTNCTL_WIDTH = 32
) ();
    logic                    mc_rq_vld;
    logic [2:0]              mc_rq_cmd;
    logic [3:0]              mc_rq_scmd;
    logic [47:0]             mc_rq_vadr;
    logic [1:0]              mc_rq_size;
    logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
    logic [63:0]             mc_rq_data;
    logic                    mc_rq_flush;
    logic                    mc_rq_stall;
    logic                    mc_rs_vld;
    logic [2:0]              mc_rs_cmd;
    logic [3:0]              mc_rs_scmd;
    logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
    logic [63:0]             mc_rs_data;
    logic                    mc_rs_stall;
    logic                    mc_rs_flush_cmplt;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data, mc_rs_flush_cmplt
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
               mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
               mc_rs_data, mc_rs_flush_cmplt
    );
endinterface
`default_nettype wire

// File: rtl/mc_rsp_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mc_rsp_model
//  Description : Memory-controller responder. Accepts RD8/WR8 requests into a
//                word-addressed memory and returns in-order responses after a
//                fixed latency, with response backpressure and write flush.
//  Ports       : clk      - clock
//                rst_n    - asynchronous active-low reset
//                mc       - MC request/response bundle (slave side)
//                err_cnt  - saturating count of unsupported-command requests
//  Revision    : 1.0  initial release
// ============================================================================
module mc_rsp_model #(
    parameter int RTNCTL_WIDTH = 32,
    parameter int ADDR_BITS    = 10,
    parameter int LATENCY      = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_rsp_model_if.slave mc,
    output logic [15:0]   err_cnt
);

    localparam int DEPTH_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    // The FIFO write itself is the last of the LATENCY register stages, so
    // only LATENCY-1 pipeline registers sit in front of it.
    localparam int PIPE_N  = (LATENCY > 1) ? LATENCY - 1 : 1;

    localparam logic [2:0] RQ_RD8      = 3'd1;
    localparam logic [2:0] RQ_WR8      = 3'd2;
    localparam logic [2:0] RS_RD8_DATA = 3'd2;
    localparam logic [2:0] RS_WR_CMP   = 3'd3;

    typedef struct packed {
        logic [2:0]              cmd;
        logic [63:0]             data;
        logic [RTNCTL_WIDTH-1:0] rtnctl;
    } ent_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]             mem_q [2**ADDR_BITS];
    ent_t                    fifo_q [FIFO_DEPTH];
    logic [DEPTH_W:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    cmplt_q;
    logic                    rs_vld_q;
    logic [2:0]              rs_cmd_q;
    logic [RTNCTL_WIDTH-1:0] rs_rtnctl_q;
    logic [63:0]             rs_data_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_acc, w_is_rd, w_is_wr, w_push, w_bad;
    ent_t                 w_acc_ent;

    assign w_idx   = mc.mc_rq_vadr[ADDR_BITS+2:3];
    assign w_acc   = mc.mc_rq_vld && !mc.mc_rq_stall;
    assign w_is_rd = (mc.mc_rq_cmd == RQ_RD8);
    assign w_is_wr = (mc.mc_rq_cmd == RQ_WR8);
    assign w_push  = w_acc && (w_is_rd || w_is_wr);
    assign w_bad   = w_acc && !(w_is_rd || w_is_wr);

    // Read data is captured at accept time so later writes cannot alter it.
    assign w_acc_ent.cmd    = w_is_rd ? RS_RD8_DATA : RS_WR_CMP;
    assign w_acc_ent.data   = w_is_rd ? mem_q[w_idx] : 64'd0;
    assign w_acc_ent.rtnctl = mc.mc_rq_rtnctl;

    logic w_unused;
    assign w_unused = ^{mc.mc_rq_scmd, mc.mc_rq_size,
                        mc.mc_rq_vadr[47:ADDR_BITS+3], mc.mc_rq_vadr[2:0]};

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_acc && w_is_wr) begin
            mem_q[w_idx] <= mc.mc_rq_data;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipeline
    // ------------------------------------------------------------------
    logic w_fifo_wr;
    ent_t w_fifo_wdata;
    logic w_pipe_busy;

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [PIPE_N-1:0] vld_q;
            ent_t              ent_q [PIPE_N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < PIPE_N; i++) begin
                        ent_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= w_push;
                    ent_q[0] <= w_acc_ent;
                    for (int i = 1; i < PIPE_N; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        ent_q[i] <= ent_q[i-1];
                    end
                end
            end

            assign w_fifo_wr    = vld_q[PIPE_N-1];
            assign w_fifo_wdata = ent_q[PIPE_N-1];
            assign w_pipe_busy  = |vld_q;
        end else begin : g_nopipe
            assign w_fifo_wr    = w_push;
            assign w_fifo_wdata = w_acc_ent;
            assign w_pipe_busy  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response FIFO (cannot overflow: cnt gates acceptance)
    // ------------------------------------------------------------------
    logic w_empty, w_pop;
    ent_t w_head;

    assign w_empty = (wptr_q == rptr_q);
    assign w_pop   = !w_empty && !mc.mc_rs_stall;
    assign w_head  = fifo_q[rptr_q[DEPTH_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            fifo_q[wptr_q[DEPTH_W-1:0]] <= w_fifo_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic w_flush_done;

    // Completion waits for the last response to have left the output
    // register, so cmplt always follows the final WR_CMP.
    assign w_flush_done = flush_pend_q && (cnt_q == '0) && !w_pipe_busy && !rs_vld_q;

    always_comb begin
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;
        flush_pend_d = flush_pend_q;

        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_push && w_pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (w_bad && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // A flush arriving while one is pending merges into it.
        if (flush_pend_q) begin
            flush_pend_d = !w_flush_done;
        end else begin
            flush_pend_d = mc.mc_rq_flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            err_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            cmplt_q      <= 1'b0;
            rs_vld_q     <= 1'b0;
            rs_cmd_q     <= '0;
            rs_rtnctl_q  <= '0;
            rs_data_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
            flush_pend_q <= flush_pend_d;
            cmplt_q      <= w_flush_done;
            rs_vld_q     <= w_pop;
            if (w_fifo_wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q      <= rptr_q + 1'b1;
                rs_cmd_q    <= w_head.cmd;
                rs_rtnctl_q <= w_head.rtnctl;
                rs_data_q   <= w_head.data;
            end else begin
                rs_cmd_q    <= '0;
                rs_rtnctl_q <= '0;
                rs_data_q   <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mc.mc_rq_stall       = (cnt_q == CNT_W'(FIFO_DEPTH)) || flush_pend_q;
    assign mc.mc_rs_vld         = rs_vld_q;
    assign mc.mc_rs_cmd         = rs_cmd_q;
    assign mc.mc_rs_scmd        = 4'd0;
    assign mc.mc_rs_rtnctl      = rs_rtnctl_q;
    assign mc.mc_rs_data        = rs_data_q;
    assign mc.mc_rs_flush_cmplt = cmplt_q;
    assign err_cnt              = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_rsp_model.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mc_rsp_model
//  Description : Self-checking bench for mc_rsp_model. A transaction-level
//                model (queue of outstanding responses with ready times,
//                model memory, flush flag) predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_rsp_model;

    localparam int LAT = 4;
    localparam int FD  = 8;
    localparam int AB  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] err_cnt;

    mc_rsp_model_if #(.RTNCTL_WIDTH(32)) mc ();

    mc_rsp_model #(
        .RTNCTL_WIDTH(32),
        .ADDR_BITS   (AB),
        .LATENCY     (LAT),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mc     (mc),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  cmd;
        logic [63:0] data;
        logic [31:0] rtn;
        int          ready;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mmem [1024];
    bit          written [1024];
    logic        e_vld, e_cmplt, pend;
    logic [2:0]  e_cmd;
    logic [63:0] e_data;
    logic [31:0] e_rtn;
    logic [15:0] m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_vld = 0; e_cmplt = 0; pend = 0; e_cmd = 0; e_data = 0; e_rtn = 0; m_err = 0;
    endtask

    task automatic set_idle();
        mc.mc_rq_vld = 0; mc.mc_rq_cmd = 0; mc.mc_rq_scmd = 0; mc.mc_rq_vadr = 0;
        mc.mc_rq_size = 0; mc.mc_rq_rtnctl = 0; mc.mc_rq_data = 0; mc.mc_rq_flush = 0;
    endtask

    task automatic set_req(input logic [2:0] cmd, input logic [47:0] vadr,
                           input logic [63:0] data, input logic [31:0] rtn);
        mc.mc_rq_vld = 1; mc.mc_rq_cmd = cmd; mc.mc_rq_vadr = vadr;
        mc.mc_rq_data = data; mc.mc_rq_rtnctl = rtn;
        mc.mc_rq_scmd = 4'($urandom); mc.mc_rq_size = 2'($urandom);
    endtask

    // Compare this cycle's outputs to the model, advance the model with this
    // cycle's inputs, then move to 1ns after the next rising edge.
    task automatic step();
        logic        m_stall, n_vld, n_cmplt;
        logic [2:0]  n_cmd;
        logic [63:0] n_data;
        logic [31:0] n_rtn;
        int          idx;
        exp_t        e;

        m_stall = (q.size() == FD) || pend;
        chk("rq_stall", mc.mc_rq_stall, m_stall);
        chk("rs_vld", mc.mc_rs_vld, e_vld);
        if (e_vld) begin
            chk("rs_cmd", mc.mc_rs_cmd, e_cmd);
            chk("rs_data", mc.mc_rs_data, e_data);
            chk("rs_rtnctl", mc.mc_rs_rtnctl, e_rtn);
        end
        chk("rs_scmd", mc.mc_rs_scmd, 0);
        chk("flush_cmplt", mc.mc_rs_flush_cmplt, e_cmplt);
        chk("err_cnt", err_cnt, m_err);

        n_cmplt = pend && (q.size() == 0) && !e_vld;
        n_vld = 0; n_cmd = 0; n_data = 0; n_rtn = 0;
        if (q.size() != 0 && q[0].ready <= cyc && !mc.mc_rs_stall) begin
            e = q.pop_front();
            n_vld = 1; n_cmd = e.cmd; n_data = e.data; n_rtn = e.rtn;
        end
        if (mc.mc_rq_vld && !m_stall) begin
            idx = int'((mc.mc_rq_vadr >> 3) % 1024);
            if (mc.mc_rq_cmd == 3'd1) begin
                q.push_back('{3'd2, mmem[idx], mc.mc_rq_rtnctl, cyc + LAT});
            end else if (mc.mc_rq_cmd == 3'd2) begin
                mmem[idx] = mc.mc_rq_data;
                written[idx] = 1;
                q.push_back('{3'd3, 64'd0, mc.mc_rq_rtnctl, cyc + LAT});
            end else if (m_err != 16'hFFFF) begin
                m_err = m_err + 16'd1;
            end
        end
        pend = pend ? !n_cmplt : mc.mc_rq_flush;
        e_vld = n_vld; e_cmd = n_cmd; e_data = n_data; e_rtn = n_rtn; e_cmplt = n_cmplt;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rq_stall"}, mc.mc_rq_stall, 0);
        chk({tag, "_rs_vld"}, mc.mc_rs_vld, 0);
        chk({tag, "_rs_cmd"}, mc.mc_rs_cmd, 0);
        chk({tag, "_rs_data"}, mc.mc_rs_data, 0);
        chk({tag, "_rs_rtnctl"}, mc.mc_rs_rtnctl, 0);
        chk({tag, "_cmplt"}, mc.mc_rs_flush_cmplt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  cmd;
        logic [47:0] vadr;
        logic [63:0] data;
        logic [31:0] rtn;
        logic        exp_rsp;
        logic [2:0]  exp_cmd;
        logic [63:0] exp_data;
    } vec_t;

    vec_t tv [5];

    initial begin
        int acc, n, first, last, last_wr, c_idx, n_c;
        logic prev_stall;
        logic got;
        int lat;
        logic [2:0] g_cmd;
        logic [63:0] g_data;
        logic [31:0] g_rtn;

        tv[0] = '{3'd2, 48'h40,   64'hDEADBEEF, 32'd5, 1'b1, 3'd3, 64'd0};
        tv[1] = '{3'd1, 48'h40,   64'd0,        32'd6, 1'b1, 3'd2, 64'hDEADBEEF};
        tv[2] = '{3'd2, 48'h2000, 64'h11,       32'd7, 1'b1, 3'd3, 64'd0};
        tv[3] = '{3'd1, 48'h0,    64'd0,        32'd8, 1'b1, 3'd2, 64'h11};
        tv[4] = '{3'd5, 48'h80,   64'h99,       32'd9, 1'b0, 3'd0, 64'd0};

        rst_n = 0;
        set_idle();
        mc.mc_rs_stall = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        // ---- table-driven single transactions ----
        foreach (tv[i]) begin
            set_req(tv[i].cmd, tv[i].vadr, tv[i].data, tv[i].rtn);
            step();
            set_idle();
            got = 0; lat = 0; g_cmd = 0; g_data = 0; g_rtn = 0;
            for (int k = 1; k <= 12; k++) begin
                if (mc.mc_rs_vld && !got) begin
                    got = 1; lat = k;
                    g_cmd = mc.mc_rs_cmd; g_data = mc.mc_rs_data; g_rtn = mc.mc_rs_rtnctl;
                end
                step();
            end
            chk("tv_rsp_seen", got, tv[i].exp_rsp);
            if (tv[i].exp_rsp) begin
                chk("tv_latency", lat, LAT + 1);
                chk("tv_cmd", g_cmd, tv[i].exp_cmd);
                chk("tv_data", g_data, tv[i].exp_data);
                chk("tv_rtnctl", g_rtn, tv[i].rtn);
            end
        end
        chk("tv_err_cnt", err_cnt, 1);

        // ---- fill under response backpressure ----
        mc.mc_rs_stall = 1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            set_req(3'd1, 48'h40, 64'd0, 32'd100 + 32'(i));
            if (!mc.mc_rq_stall) acc++;
            step();
        end
        set_idle();
        repeat (LAT + 2) step();
        chk("bp_accepted", acc, 8);
        chk("bp_stall_full", mc.mc_rq_stall, 1);
        mc.mc_rs_stall = 0;
        n = 0; first = -1; last = -1;
        for (int k = 0; k < 20; k++) begin
            if (mc.mc_rs_vld) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
            step();
        end
        chk("bp_rsp_count", n, 8);
        chk("bp_no_gaps", last - first + 1, 8);
        chk("bp_stall_drop", mc.mc_rq_stall, 0);

        // ---- toggling response stall ----
        n = 0; prev_stall = 0;
        for (int k = 0; k < 30; k++) begin
            if (mc.mc_rs_vld) begin
                n++;
                chk("tog_prev_low", prev_stall, 0);
            end
            mc.mc_rs_stall = k[0];
            prev_stall = mc.mc_rs_stall;
            if (k < 4) set_req(3'd1, 48'h2000, 64'd0, 32'd200 + 32'(k));
            else set_idle();
            step();
        end
        chk("tog_rsp_count", n, 4);
        mc.mc_rs_stall = 0;
        set_idle();
        step();

        // ---- flush after three writes ----
        for (int i = 0; i < 3; i++) begin
            set_req(3'd2, 48'h100 + 48'(8 * i), 64'hA0 + 64'(i), 32'd300 + 32'(i));
            step();
        end
        set_idle();
        mc.mc_rq_flush = 1;
        step();
        mc.mc_rq_flush = 0;
        chk("flush_stall", mc.mc_rq_stall, 1);
        last_wr = -1; c_idx = -1; n_c = 0;
        for (int k = 0; k < 30; k++) begin
            if (mc.mc_rs_vld && mc.mc_rs_cmd == 3'd3) last_wr = k;
            if (mc.mc_rs_flush_cmplt) begin n_c++; c_idx = k; end
            step();
        end
        chk("flush_cmplt_once", n_c, 1);
        chk("flush_after_wrcmp", (c_idx > last_wr) && (last_wr >= 0), 1);

        // ---- flush with nothing outstanding ----
        mc.mc_rq_flush = 1;
        step();
        mc.mc_rq_flush = 0;
        c_idx = -1;
        for (int k = 1; k <= 6; k++) begin
            if (mc.mc_rs_flush_cmplt) c_idx = k;
            step();
        end
        chk("flush_idle_t2", c_idx, 2);

        // ---- asynchronous reset with requests in flight ----
        for (int i = 0; i < 3; i++) begin
            set_req(3'd1, 48'h40, 64'd0, 32'd400 + 32'(i));
            step();
        end
        set_idle();
        step();
        #2;
        rst_n = 0;
        #1;
        chk_outs_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            if (mc.mc_rs_vld) n++;
            step();
        end
        chk("post_reset_no_rsp", n, 0);

        // ---- randomized traffic ----
        for (int k = 0; k < 600; k++) begin
            logic [47:0] va;
            logic [2:0]  cmd;
            int          r, widx;
            set_idle();
            r = int'($urandom_range(0, 7));
            widx = int'($urandom_range(0, 15));
            va = {16'($urandom), 32'($urandom)};
            va[AB+2:3] = AB'(widx);
            cmd = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r == 6) ? 3'd5 : 3'd0;
            if (cmd == 3'd1 && !written[widx]) cmd = 3'd2;
            if ($urandom_range(0, 2) != 0) set_req(cmd, va, {$urandom, $urandom}, $urandom);
            mc.mc_rq_flush = ($urandom_range(0, 49) == 0);
            mc.mc_rs_stall = ($urandom_range(0, 3) == 0);
            step();
        end
        set_idle();
        mc.mc_rs_stall = 0;
        repeat (30) step();
        chk("drain_empty", mc.mc_rq_stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
